// File: rtl/syscall_display_pkg.sv
// syscall_display_pkg: shared constants for the syscall display scanner.
// Holds the digit geometry, idle/off patterns and the hex glyph table
// (active-low cathodes, bit order {g,f,e,d,c,b,a}).
package syscall_display_pkg;

  localparam int DIGIT_COUNT = 8;
  localparam int DIGIT_BITS  = 3;

  localparam logic [7:0] ANODES_IDLE = 8'hFF;
  localparam logic [6:0] SEG_OFF     = 7'h7F;

  // Glyphs 0-9, A, b, C, d, E, F ('b' and 'd' lowercase so they differ from 8 and 0)
  localparam logic [6:0] HEX_GLYPHS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/syscall_display_scanner_if.sv
// syscall_display_scanner_if: value/control inputs from the syscall
// controller plus the multiplexed display drive outputs.
interface syscall_display_scanner_if;

  logic [31:0] valueIn;
  logic        running;
  logic        blank;
  logic [7:0]  anodes;
  logic [6:0]  segments;
  logic        dp;

  // Source side: drives the value and controls, watches the display pins
  modport master (
    output valueIn, running, blank,
    input  anodes, segments, dp
  );

  // Scanner side
  modport slave (
    input  valueIn, running, blank,
    output anodes, segments, dp
  );

endinterface

// File: rtl/syscall_display_scanner_hex_to_seg.sv
// hex_to_seg: combinational nibble to active-low seven-segment glyph.
module hex_to_seg
  import syscall_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Table lookup of the glyph for the selected nibble
  always_comb begin
    seg_o = HEX_GLYPHS[nibble_i];
  end

endmodule

// File: rtl/syscall_display_scanner.sv
// syscall_display_scanner: scans a 32-bit value as 8 hex digits onto a
// common-anode multiplexed display. The value is latched only at frame
// boundaries so a frame never tears; digit 0's decimal point blinks while
// the CPU is halted.
// Optional build macro SYSCALL_DISPLAY_LEADING_ZERO_BLANK_EN darkens digits
// above the highest nonzero nibble (digit 0 always shown).
module syscall_display_scanner
  import syscall_display_pkg::*;
#(
  parameter int SCAN_DIVIDER = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input logic                      clock,
  input logic                      reset,
  syscall_display_scanner_if.slave bus
);

  localparam int PRE_W = $clog2(SCAN_DIVIDER);
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PRE_W-1:0]      PRE_LAST   = PRE_W'(SCAN_DIVIDER - 1);
  localparam logic [FRM_W-1:0]      FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [DIGIT_BITS-1:0] DIGIT_LAST = DIGIT_BITS'(DIGIT_COUNT - 1);
  localparam logic [DIGIT_BITS-1:0] DIGIT_ZERO = DIGIT_BITS'(0);

  logic [PRE_W-1:0]      prescaler_q, prescaler_d;
  logic [DIGIT_BITS-1:0] digit_q, digit_d;
  logic [31:0]           shadow_q, shadow_d;
  logic [FRM_W-1:0]      frame_q, frame_d;
  logic                  blink_q, blink_d;
  logic [7:0]            anodes_q, anodes_d;
  logic [6:0]            segments_q, segments_d;
  logic                  dp_q, dp_d;

  logic                  tick_s;
  logic                  boundary_s;
  logic [DIGIT_BITS-1:0] digit_next_s;
  logic [31:0]           src_s;
  logic [3:0]            nibble_s;
  logic [6:0]            glyph_s;
  logic                  lit_s;

  // Scan timing and selection of the nibble for the digit about to be shown;
  // at a frame boundary the incoming value is used so digit 0 of the new
  // frame already reflects the freshly latched shadow.
  always_comb begin
    tick_s       = (prescaler_q == PRE_LAST);
    boundary_s   = tick_s && (digit_q == DIGIT_LAST);
    digit_next_s = digit_q + DIGIT_BITS'(1);
    if (boundary_s) begin
      src_s = bus.valueIn;
    end else begin
      src_s = shadow_q;
    end
    nibble_s = src_s[{digit_next_s, 2'b00} +: 4];
`ifdef SYSCALL_DISPLAY_LEADING_ZERO_BLANK_EN
    if (digit_next_s == DIGIT_ZERO) begin
      lit_s = 1'b1;
    end else begin
      lit_s = ((src_s >> {digit_next_s, 2'b00}) != 32'd0);
    end
`else
    lit_s = 1'b1;
`endif
  end

  hex_to_seg u_hex_to_seg (
    .nibble_i (nibble_s),
    .seg_o    (glyph_s)
  );

  // Next-state for counters, shadow latch, halt blinker and display outputs
  always_comb begin
    if (tick_s) begin
      prescaler_d = PRE_W'(0);
      digit_d     = digit_next_s;
      segments_d  = glyph_s;
      if (bus.blank || !lit_s) begin
        anodes_d = ANODES_IDLE;
      end else begin
        anodes_d = ~(8'h01 << digit_next_s);
      end
    end else begin
      prescaler_d = prescaler_q + PRE_W'(1);
      digit_d     = digit_q;
      segments_d  = segments_q;
      anodes_d    = anodes_q;
    end

    if (boundary_s) begin
      shadow_d = bus.valueIn;
    end else begin
      shadow_d = shadow_q;
    end

    // Running clears the blinker every cycle, winning over a boundary update
    if (bus.running) begin
      frame_d = FRM_W'(0);
      blink_d = 1'b0;
    end else if (boundary_s) begin
      if (frame_q == FRM_LAST) begin
        frame_d = FRM_W'(0);
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + FRM_W'(1);
        blink_d = blink_q;
      end
    end else begin
      frame_d = frame_q;
      blink_d = blink_q;
    end

    // Decimal point extinguished immediately on run, else refreshed per tick
    if (bus.running) begin
      dp_d = 1'b1;
    end else if (tick_s) begin
      dp_d = ~((digit_next_s == DIGIT_ZERO) && blink_q);
    end else begin
      dp_d = dp_q;
    end
  end

  // State registers with asynchronous reset to digit 0 showing "0"
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler_q <= PRE_W'(0);
      digit_q     <= DIGIT_ZERO;
      shadow_q    <= 32'd0;
      frame_q     <= FRM_W'(0);
      blink_q     <= 1'b0;
      anodes_q    <= 8'hFE;
      segments_q  <= 7'b1000000;
      dp_q        <= 1'b1;
    end else begin
      prescaler_q <= prescaler_d;
      digit_q     <= digit_d;
      shadow_q    <= shadow_d;
      frame_q     <= frame_d;
      blink_q     <= blink_d;
      anodes_q    <= anodes_d;
      segments_q  <= segments_d;
      dp_q        <= dp_d;
    end
  end

  assign bus.anodes   = anodes_q;
  assign bus.segments = segments_q;
  assign bus.dp       = dp_q;

endmodule
